// File: rtl/riscv_dcache_pkg.sv
// Shared constants, FSM state encoding and byte-merge helpers for the data cache.
package riscv_dcache_pkg;

    localparam int CACHE_LINE_W = 128;
    localparam int CACHE_MASK_W = CACHE_LINE_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WB_REQ    = 3'd1,
        ST_WB_DATA   = 3'd2,
        ST_FILL_REQ  = 3'd3,
        ST_FILL_WAIT = 3'd4
    } state_t;

    // Expand a 4-bit word write mask into a 16-bit line byte-enable.
    function automatic logic [CACHE_MASK_W-1:0] word_be(input logic [3:0] we,
                                                         input logic [1:0] word);
        word_be = {12'b0, we} << {word, 2'b00};
    endfunction

    function automatic logic [CACHE_LINE_W-1:0] merge_line(input logic [CACHE_LINE_W-1:0] line,
                                                           input logic [CACHE_MASK_W-1:0] be,
                                                           input logic [31:0]             din);
        merge_line = line;
        for (int b = 0; b < CACHE_MASK_W; b++) begin
            if (be[b]) merge_line[b*8 +: 8] = din[(b % 4)*8 +: 8];
        end
    endfunction

endpackage

// File: rtl/riscv_dcache_cache_data_array.sv
// Line storage for the direct-mapped cache: data, tag, valid and dirty per line,
// one shared index with asynchronous read and byte-enabled synchronous write.
module cache_data_array
    import riscv_dcache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX   = $clog2(LINES),
    parameter int TAG_W = 28 - IDX
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IDX-1:0]          idx,
    output logic [CACHE_LINE_W-1:0] rd_line,
    output logic [TAG_W-1:0]        rd_tag,
    output logic                    rd_valid,
    output logic                    rd_dirty,
    input  logic                    wr_en,
    input  logic [CACHE_MASK_W-1:0] wr_be,
    input  logic [CACHE_LINE_W-1:0] wr_data,
    input  logic [TAG_W-1:0]        wr_tag,
    input  logic                    wr_dirty
);

    logic [CACHE_LINE_W-1:0] data_q [LINES];
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [LINES-1:0]        valid_q;
    logic [LINES-1:0]        dirty_q;

    assign rd_line  = data_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];

    // Only the bookkeeping bits are reset; data and tags are meaningless until valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[idx] <= wr_tag;
            for (int b = 0; b < CACHE_MASK_W; b++) begin
                if (wr_be[b]) data_q[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/riscv_dcache.sv
// Direct-mapped write-back, write-allocate data cache between the core data port
// and a 128-bit line-oriented memory interface.
module riscv_dcache
    import riscv_dcache_pkg::*;
#(
    parameter int LINES  = 64,
    parameter int LINE_W = CACHE_LINE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         dcache_addr,
    input  logic                dcache_re,
    input  logic [3:0]          dcache_we,
    input  logic [31:0]         dcache_din,
    output logic [31:0]         dcache_dout,
    output logic                stall,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_rw,
    output logic [27:0]         mem_req_addr,
    output logic                mem_req_data_valid,
    input  logic                mem_req_data_ready,
    output logic [LINE_W-1:0]   mem_req_data_bits,
    output logic [LINE_W/8-1:0] mem_req_data_mask,
    input  logic                mem_resp_valid,
    input  logic [LINE_W-1:0]   mem_resp_data
);

    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = 28 - IDX;

    state_t state_q, state_d;

    logic [31:2] miss_addr_p1;
    logic [3:0]  miss_we_p1;
    logic [31:0] miss_din_p1;

    logic [IDX-1:0]          arr_idx;
    logic [CACHE_LINE_W-1:0] arr_line;
    logic [TAG_W-1:0]        arr_tag;
    logic                    arr_valid;
    logic                    arr_dirty;
    logic                    wr_en;
    logic [CACHE_MASK_W-1:0] wr_be;
    logic [CACHE_LINE_W-1:0] wr_data;
    logic [TAG_W-1:0]        wr_tag;
    logic                    wr_dirty;

    logic        idle, wr_req, req, hit;
    logic        accept_miss, rd_hit, wr_hit, fill_done;
    logic [31:0] hit_word, fill_word;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^dcache_addr[1:0];

    assign idle   = (state_q == ST_IDLE);
    assign wr_req = |dcache_we;
    assign req    = dcache_re | wr_req;

    // In IDLE the array looks at the live core address; during a miss it is pinned to the latched one.
    assign arr_idx = idle ? dcache_addr[3+IDX:4] : miss_addr_p1[3+IDX:4];

    cache_data_array #(.LINES(LINES)) u_array (
        .clk      (clk),
        .reset    (reset),
        .idx      (arr_idx),
        .rd_line  (arr_line),
        .rd_tag   (arr_tag),
        .rd_valid (arr_valid),
        .rd_dirty (arr_dirty),
        .wr_en    (wr_en),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .wr_tag   (wr_tag),
        .wr_dirty (wr_dirty)
    );

    assign hit         = arr_valid && (arr_tag == dcache_addr[31:4+IDX]);
    assign accept_miss = idle && req && !hit;
    assign rd_hit      = idle && dcache_re && !wr_req && hit;
    assign wr_hit      = idle && wr_req && hit;
    assign fill_done   = (state_q == ST_FILL_WAIT) && mem_resp_valid;
    assign hit_word    = arr_line[{dcache_addr[3:2], 5'b0} +: 32];
    assign fill_word   = mem_resp_data[{miss_addr_p1[3:2], 5'b0} +: 32];

    // A pending write miss is folded into the fill line so the array sees a single write.
    always_comb begin
        wr_en    = 1'b0;
        wr_be    = '0;
        wr_data  = '0;
        wr_tag   = arr_tag;
        wr_dirty = 1'b0;
        if (wr_hit) begin
            wr_en    = 1'b1;
            wr_be    = word_be(dcache_we, dcache_addr[3:2]);
            wr_data  = {4{dcache_din}};
            wr_dirty = 1'b1;
        end else if (fill_done) begin
            wr_en    = 1'b1;
            wr_be    = '1;
            wr_data  = merge_line(mem_resp_data,
                                  word_be(miss_we_p1, miss_addr_p1[3:2]), miss_din_p1);
            wr_tag   = miss_addr_p1[31:4+IDX];
            wr_dirty = |miss_we_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (accept_miss) state_d = (arr_valid && arr_dirty) ? ST_WB_REQ : ST_FILL_REQ;
            ST_WB_REQ:    if (mem_req_ready) state_d = ST_WB_DATA;
            ST_WB_DATA:   if (mem_req_data_ready) state_d = ST_FILL_REQ;
            ST_FILL_REQ:  if (mem_req_ready) state_d = ST_FILL_WAIT;
            ST_FILL_WAIT: if (mem_resp_valid) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = miss_addr_p1[31:4];
        mem_req_data_valid = 1'b0;
        case (state_q)
            ST_WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {arr_tag, miss_addr_p1[3+IDX:4]};
            end
            ST_WB_DATA:  mem_req_data_valid = 1'b1;
            ST_FILL_REQ: mem_req_valid      = 1'b1;
            default: ;
        endcase
    end

    assign mem_req_data_bits = arr_line;
    assign mem_req_data_mask = '1;

    // Stage p1: core-visible response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stall       <= 1'b0;
            dcache_dout <= '0;
        end else begin
            if (accept_miss)    stall <= 1'b1;
            else if (fill_done) stall <= 1'b0;
            if (rd_hit)                         dcache_dout <= hit_word;
            else if (fill_done && !(|miss_we_p1)) dcache_dout <= fill_word;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_miss) begin
            miss_addr_p1 <= dcache_addr[31:2];
            miss_we_p1   <= dcache_we;
            miss_din_p1  <= dcache_din;
        end
    end

endmodule

// File: tb/tb_riscv_dcache.sv
// Randomized bench for riscv_dcache: an architectural memory model predicts read data,
// a tag/valid/dirty map predicts hits and write-backs, and the bench plays main memory.
module tb_riscv_dcache;

    localparam int LINES = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  dcache_addr;
    logic         dcache_re;
    logic [3:0]   dcache_we;
    logic [31:0]  dcache_din;
    logic [31:0]  dcache_dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic         mem_req_data_valid;
    logic         mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    always #5 clk = ~clk;

    riscv_dcache #(.LINES(LINES)) dut (
        .clk                (clk),
        .reset              (reset),
        .dcache_addr        (dcache_addr),
        .dcache_re          (dcache_re),
        .dcache_we          (dcache_we),
        .dcache_din         (dcache_din),
        .dcache_dout        (dcache_dout),
        .stall              (stall),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural contents (what the core should read) and main-memory contents.
    logic [127:0] ref_mem [int];
    logic [127:0] bk_mem  [int];
    bit           mvalid  [LINES];
    bit           mdirty  [LINES];
    int           mtag    [LINES];
    logic [31:0]  exp_dout;

    task automatic touch(input int la);
        logic [127:0] seed;
        seed = {32'(la*4+3) ^ 32'h5A00_0000, 32'(la*4+2) ^ 32'h3C00_0000,
                32'(la*4+1) ^ 32'h9600_0000, 32'(la*4)   ^ 32'hC300_0000};
        if (!bk_mem.exists(la))  bk_mem[la]  = seed;
        if (!ref_mem.exists(la)) ref_mem[la] = seed;
    endtask

    task automatic clear_model();
        for (int i = 0; i < LINES; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
            mtag[i]   = 0;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where the request completed.
    task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] din,
                          input bit junk, input int hold);
        int la, idx, tag, word, victim, wb_cnt, fill_cnt, resp_wait, hold_left;
        bit hit, exp_wb, resp_pending, resp_sent, hold_started;
        logic [27:0]  hold_addr;
        logic [127:0] line;
        la     = int'(a[31:4]);
        idx    = la % LINES;
        tag    = la / LINES;
        word   = int'(a[3:2]);
        touch(la);
        hit    = mvalid[idx] && (mtag[idx] == tag);
        exp_wb = !hit && mvalid[idx] && mdirty[idx];
        victim = mtag[idx] * LINES + idx;

        dcache_addr = a;
        dcache_we   = we;
        dcache_din  = din;
        dcache_re   = (we == 4'b0) | junk;
        if (junk) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        check_eq("stall_on_accept", stall, !hit);
        if (hit) check_eq("hit_no_mem_req", mem_req_valid, 1'b0);

        if (!hit) begin
            hold_left = hold; hold_started = 0; hold_addr = '0;
            resp_pending = 0; resp_sent = 0; resp_wait = 0; wb_cnt = 0; fill_cnt = 0;
            for (int cyc = 0; cyc < 200; cyc++) begin
                mem_req_ready = 1'b0; mem_req_data_ready = 1'b0; mem_resp_valid = 1'b0;
                if (resp_pending) begin
                    if (resp_wait == 0) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data  = bk_mem[la];
                        resp_pending   = 0;
                        resp_sent      = 1;
                    end else resp_wait--;
                end
                if (hold_left > 0 && (hold_started || mem_req_valid)) begin
                    if (!hold_started) begin
                        hold_started = 1;
                        hold_addr    = mem_req_addr;
                    end
                    check_eq("hold_valid", mem_req_valid, 1'b1);
                    check_eq("hold_addr", mem_req_addr, hold_addr);
                    check_eq("hold_stall", stall, 1'b1);
                    hold_left--;
                end else if (mem_req_valid && $urandom_range(0, 1) == 1) begin
                    mem_req_ready = 1'b1;
                    if (mem_req_rw) begin
                        wb_cnt++;
                        check_eq("wb_addr", mem_req_addr, 28'(victim));
                    end else begin
                        fill_cnt++;
                        check_eq("fill_addr", mem_req_addr, 28'(la));
                        check_eq("wb_before_fill", wb_cnt, exp_wb);
                        resp_pending = 1;
                        resp_wait    = $urandom_range(0, 3);
                    end
                end
                if (mem_req_data_valid && $urandom_range(0, 1) == 1) begin
                    mem_req_data_ready = 1'b1;
                    check_eq("wb_mask", mem_req_data_mask, 16'hFFFF);
                    check_eq("wb_data", mem_req_data_bits, ref_mem[victim]);
                    bk_mem[victim] = mem_req_data_bits;
                end
                @(posedge clk); #1;
                if (!stall) break;
            end
            mem_req_ready = 1'b0; mem_req_data_ready = 1'b0; mem_resp_valid = 1'b0;
            check_eq("miss_done", {resp_sent, stall}, 2'b10);
            check_eq("wb_count", wb_cnt, exp_wb);
            check_eq("fill_count", fill_cnt, 1);
        end
        dcache_re = 1'b0;
        dcache_we = 4'b0;

        line = ref_mem[la];
        for (int b = 0; b < 4; b++) begin
            if (we[b]) line[word*32 + b*8 +: 8] = din[b*8 +: 8];
        end
        ref_mem[la] = line;
        if (we == 4'b0) exp_dout = line[word*32 +: 32];
        check_eq("dout", dcache_dout, exp_dout);
        if (!hit) begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = tag;
            mdirty[idx] = (we != 4'b0);
        end else if (we != 4'b0) begin
            mdirty[idx] = 1'b1;
        end
    endtask

    initial begin
        int idx_pool [6];
        bit granted;
        logic [31:0] a;
        logic [3:0]  we;
        idx_pool = '{0, 1, 2, 16, 62, 63};

        reset = 1'b1; dcache_addr = '0; dcache_re = 1'b0; dcache_we = '0; dcache_din = '0;
        mem_req_ready = 1'b0; mem_req_data_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        bk_mem[16]  = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        ref_mem[16] = bk_mem[16];
        clear_model();
        exp_dout = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_dout", dcache_dout, 32'h0);
        check_eq("rst_req_valid", mem_req_valid, 1'b0);
        check_eq("rst_data_valid", mem_req_data_valid, 1'b0);
        reset = 1'b0;

        access(32'h100, 4'b0, 32'h0, 0, 0);
        check_eq("cold_read_dout", dcache_dout, 32'hAAAAAAAA);
        access(32'h104, 4'b0, 32'h0, 0, 0);
        check_eq("hit_read_dout", dcache_dout, 32'hBBBBBBBB);
        access(32'h108, 4'b0011, 32'h12345678, 0, 0);
        access(32'h108, 4'b0, 32'h0, 0, 0);
        check_eq("merged_read", dcache_dout, 32'hCCCC5678);
        access(32'h100 + LINES*16, 4'b0, 32'h0, 0, 5);
        check_eq("conflict_wb_line", bk_mem[16],
                 {32'hDDDDDDDD, 32'hCCCC5678, 32'hBBBBBBBB, 32'hAAAAAAAA});

        // Abort a fill in FILL_WAIT with reset.
        dcache_addr = 32'h2000; dcache_re = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_stall", stall, 1'b1);
        granted = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            mem_req_ready = mem_req_valid;
            @(posedge clk); #1;
            if (mem_req_ready) begin
                granted = 1;
                break;
            end
        end
        mem_req_ready = 1'b0;
        check_eq("abort_fill_granted", granted, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_eq("fill_wait_no_req", mem_req_valid, 1'b0);
        check_eq("fill_wait_stall", stall, 1'b1);
        reset = 1'b1; dcache_re = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("abort_stall_clr", stall, 1'b0);
        check_eq("abort_dout", dcache_dout, 32'h0);
        check_eq("abort_req_valid", mem_req_valid, 1'b0);
        mem_resp_valid = 1'b1; mem_resp_data = {4{32'hDEADBEEF}};
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        check_eq("stray_resp_ignored", stall, 1'b0);
        clear_model();
        ref_mem = bk_mem;
        exp_dout = '0;
        access(32'h100, 4'b0, 32'h0, 0, 0);
        check_eq("post_reset_read", dcache_dout, 32'hAAAAAAAA);

        for (int n = 0; n < 300; n++) begin
            a  = 32'(($urandom_range(0, 3) * LINES + idx_pool[$urandom_range(0, 5)]) * 16
                     + $urandom_range(0, 3) * 4);
            we = ($urandom_range(0, 1) == 1) ? 4'(($urandom_range(1, 15))) : 4'b0;
            access(a, we, $urandom(), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
